synth_control_sequencer: RTL and testbench
==========================================

Name: synth_control_sequencer

Overview:
- Parametrised front-end for the time-multiplexed FM synth core.
- Owns the voice-operator slot counter, with generic voice and operator counts, and emits a frame-start strobe.
- Buffers host register writes in a FIFO, decodes them into voice-operator or global write strobes, and commits them either immediately or only at frame boundaries, so parameters never change mid-sample.
- Sits between the host register port and every pipeline stage's config write inputs.

Parameters:
NUM_VOICES, 32, voices per frame (1..32)
NUM_OPERATORS, 8, operators per voice (1..8)
FIFO_DEPTH, 16, write buffer entries (power of 2, <= NUM_VOICES*NUM_OPERATORS)

Ports:
i_Clock  in  1  system clock
i_Reset_n  in  1  asynchronous active-low reset
i_RegisterWriteEnable  in  1  host write strobe
i_RegisterWriteNumber  in  16  host register address
i_RegisterWriteValue  in  16  host write data
o_RegisterWriteReady  out  1  FIFO not full; a write while low is dropped
i_CommitMode  in  1  0 = immediate drain, 1 = frame-synchronous drain
o_VoiceOperator  out  8  current slot {op[2:0], voice[4:0]}
o_FrameStart  out  1  high while slot == 0
o_VoiceOpWriteEnable  out  1  one-cycle voice-op config strobe
o_VoiceOpParameter  out  6  parameter code
o_VoiceOpAddress  out  8  {voice[4:0], op[2:0]} target
o_GlobalWriteEnable  out  1  one-cycle global config strobe
o_GlobalAddress  out  14  global parameter / sine table index
o_WriteValue  out  16  data for either strobe
o_FifoLevel  out  $clog2(FIFO_DEPTH)+1  entries buffered
o_DropCount  out  8  saturating count of rejected writes

Behaviour:
- Reset (async assert, sync release): slot = 0, o_FrameStart = 1, FIFO empty, all strobes 0, o_DropCount = 0, pending-commit count = 0. All outputs are registered.
- Slot counter:
  - Operator is the outer loop, voice the inner loop: voice increments each cycle.
  - At voice == NUM_VOICES-1, voice wraps to 0 and op increments.
  - At {op == NUM_OPERATORS-1, voice == NUM_VOICES-1}, the slot wraps to 0.
  - o_FrameStart is registered and equals (next slot == 0), so it is high in the same cycle o_VoiceOperator == 0.
- Address decode happens at input, on a cycle with i_RegisterWriteEnable:
  - bits[15:14] = 2'b11: voice-op write. Parameter = [13:8], voice = [7:3], op = [2:0]. Rejected if voice >= NUM_VOICES or op >= NUM_OPERATORS.
  - bits[15:14] = 2'b10: global write, address = [13:0].
  - bits[15] = 0: rejected.
  - Accepted writes push a decoded entry {kind, addr, value}.
  - Rejected writes, and writes while o_RegisterWriteReady = 0, increment o_DropCount, saturating at 255.
- o_RegisterWriteReady = (level < FIFO_DEPTH), taken from the registered level. A pop in the same cycle does not free space until the next cycle.
- Simultaneous push and pop when not full: level is unchanged and both take effect.
- Immediate mode (i_CommitMode = 0):
  - Pop one entry per cycle whenever the FIFO is non-empty.
  - The strobe appears one cycle after the pop decision.
  - Latency from an accepted write into an empty FIFO to its strobe is 2 cycles.
- Frame mode (i_CommitMode = 1):
  - In the cycle the slot wraps to 0, pending = current level, including a push in that same cycle.
  - Pop one entry per cycle while pending > 0, decrementing pending on each pop.
  - Writes arriving after the latch wait for the next frame.
  - Because FIFO_DEPTH <= frame length, all latched entries commit within the frame.
- Mode switching:
  - 1 -> 0: remaining entries drain immediately; pending is cleared.
  - 0 -> 1: draining stops on the next cycle until the next frame start.
- Output strobes:
  - o_VoiceOpWriteEnable and o_GlobalWriteEnable are never both high, and each is high for exactly 1 cycle per committed entry.
  - Address, parameter and value outputs hold their last values when no strobe is active.
- Reset mid-operation discards all buffered writes. No strobe fires after reset until a new write is accepted.

Decomposition:
- synth_pkg:
  - prefix constants VOICE_OP_PREFIX = 2'b11 and GLOBAL_PREFIX = 2'b10;
  - parameter codes (PHASE_STEP = 6'h00, ALGORITHM = 01, ATTACK_LEVEL = 02, SUSTAIN_LEVEL = 03, ATTACK_RATE = 04, DECAY_RATE = 05, RELEASE_RATE = 06, FEEDBACK = 07, NOTE_ON = 10);
  - a write_entry_t struct {kind, addr[13:0], value[15:0]}.
- One sub-module: synth_write_fifo, a parametrised synchronous FIFO with push/pop, level, full and empty outputs and async active-low reset.

Test Plan:
- Release reset, run 2 frames with NUM_VOICES = 32, NUM_OPERATORS = 8 -> o_VoiceOperator steps 0, 1, … 255 and wraps; o_FrameStart is high exactly at cycles 0, 256 and 512.
- Mode 0, write 0xC00A = 0x1234 into an empty FIFO -> 2 cycles later o_VoiceOpWriteEnable = 1, parameter 0x00, address 0x0A, value 0x1234, for 1 cycle only.
- Mode 1, write three global writes (0x8005, 0x8006, 0x8007) at slot 10 -> no strobes until the frame start; then strobes appear on 3 consecutive cycles in order.
- Write 17 accepted writes back-to-back with FIFO_DEPTH = 16 in mode 1 -> ready drops after the 16th, the 17th is dropped, o_DropCount = 1, o_FifoLevel = 16.
- Write 0x4000, then set NUM_VOICES = 12 and write voice 20 -> both rejected, o_DropCount = 2, no strobes; 300 invalid writes -> o_DropCount saturates at 255.
- Assert i_Reset_n low with 5 entries buffered mid-drain -> strobes stop immediately, level = 0, slot = 0, o_FrameStart = 1; no strobe follows after release.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants and types for the FM synth control front-end.
// Host addresses carry a 2-bit prefix selecting voice-operator or global space.
package synth_pkg;

  localparam logic [1:0] VOICE_OP_PREFIX = 2'b11;
  localparam logic [1:0] GLOBAL_PREFIX   = 2'b10;

  typedef enum logic [5:0] {
    PHASE_STEP    = 6'h00,
    ALGORITHM     = 6'h01,
    ATTACK_LEVEL  = 6'h02,
    SUSTAIN_LEVEL = 6'h03,
    ATTACK_RATE   = 6'h04,
    DECAY_RATE    = 6'h05,
    RELEASE_RATE  = 6'h06,
    FEEDBACK      = 6'h07,
    NOTE_ON       = 6'h10
  } param_code_t;

  typedef enum logic {
    KIND_VOICE_OP = 1'b0,
    KIND_GLOBAL   = 1'b1
  } write_kind_t;

  // For voice-op writes addr is {param[5:0], voice[4:0], op[2:0]}; for globals it is the index.
  typedef struct packed {
    write_kind_t kind;
    logic [13:0] addr;
    logic [15:0] value;
  } write_entry_t;

  localparam int ENTRY_W = $bits(write_entry_t);

  function automatic logic voiceOpInRange(input logic [7:0] target, input int numVoices,
                                          input int numOperators);
    return (int'(target[7:3]) < numVoices) && (int'(target[2:0]) < numOperators);
  endfunction

endpackage

// File: rtl/synth_write_fifo.sv
// Generic synchronous FIFO with registered pointers/level and a combinational head read.
// A push while full or a pop while empty is ignored; a pop frees space only on the next cycle.
module synth_write_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (level == DEPTH_LVL);
  assign empty   = (level == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge i_Clock) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      level <= level + LVL_W'(doPush) - LVL_W'(doPop);
    end
  end

endmodule

// File: rtl/synth_control_sequencer.sv
// FM synth front-end: voice/operator slot counter plus buffered, decoded host config writes.
// Immediate mode strobes 2 cycles after an accepted write; frame mode defers to frame start; writes while full are dropped.
module synth_control_sequencer
  import synth_pkg::*;
#(
  parameter int NUM_VOICES    = 32,
  parameter int NUM_OPERATORS = 8,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic                          i_RegisterWriteEnable,
  input  logic [15:0]                   i_RegisterWriteNumber,
  input  logic [15:0]                   i_RegisterWriteValue,
  output logic                          o_RegisterWriteReady,
  input  logic                          i_CommitMode,
  output logic [7:0]                    o_VoiceOperator,
  output logic                          o_FrameStart,
  output logic                          o_VoiceOpWriteEnable,
  output logic [5:0]                    o_VoiceOpParameter,
  output logic [7:0]                    o_VoiceOpAddress,
  output logic                          o_GlobalWriteEnable,
  output logic [13:0]                   o_GlobalAddress,
  output logic [15:0]                   o_WriteValue,
  output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel,
  output logic [7:0]                    o_DropCount
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [4:0] LAST_VOICE = 5'(NUM_VOICES - 1);
  localparam logic [2:0] LAST_OP    = 3'(NUM_OPERATORS - 1);

  logic [4:0]         voice;
  logic [2:0]         op;
  logic               slotWrap;

  logic [1:0]         prefix;
  logic               writeValid;
  logic               pushReq;
  logic               popReq;
  logic               dropReq;
  write_entry_t       pushEntry;
  write_entry_t       headEntry;
  logic [ENTRY_W-1:0] headBits;
  logic               fifoFull;
  logic               fifoEmpty;
  logic [LEVEL_W-1:0] fifoLevel;
  logic [LEVEL_W-1:0] levelNext;
  logic [LEVEL_W-1:0] pending;

  // Voice is the inner loop, operator the outer loop.
  assign slotWrap        = (voice == LAST_VOICE) && (op == LAST_OP);
  assign o_VoiceOperator = {op, voice};

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      voice        <= '0;
      op           <= '0;
      o_FrameStart <= 1'b1;
    end else begin
      o_FrameStart <= slotWrap;
      if (voice == LAST_VOICE) begin
        voice <= '0;
        op    <= slotWrap ? 3'd0 : op + 3'd1;
      end else begin
        voice <= voice + 5'd1;
      end
    end
  end

  always_comb begin
    prefix         = i_RegisterWriteNumber[15:14];
    writeValid     = 1'b0;
    pushEntry.kind = KIND_GLOBAL;
    if (prefix == VOICE_OP_PREFIX) begin
      writeValid     = voiceOpInRange(i_RegisterWriteNumber[7:0], NUM_VOICES, NUM_OPERATORS);
      pushEntry.kind = KIND_VOICE_OP;
    end else if (prefix == GLOBAL_PREFIX) begin
      writeValid = 1'b1;
    end
    pushEntry.addr  = i_RegisterWriteNumber[13:0];
    pushEntry.value = i_RegisterWriteValue;
  end

  assign pushReq   = i_RegisterWriteEnable && writeValid && !fifoFull;
  assign dropReq   = i_RegisterWriteEnable && !pushReq;
  assign popReq    = !fifoEmpty && (!i_CommitMode || (pending != '0));
  assign levelNext = fifoLevel + LEVEL_W'(pushReq) - LEVEL_W'(popReq);
  assign headEntry = write_entry_t'(headBits);

  synth_write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) writeFifo (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .push      (pushReq),
    .pushData  (pushEntry),
    .pop       (popReq),
    .popData   (headBits),
    .level     (fifoLevel),
    .full      (fifoFull),
    .empty     (fifoEmpty)
  );

  assign o_RegisterWriteReady = !fifoFull;
  assign o_FifoLevel          = fifoLevel;

  // The frame latch counts a push landing on the wrap edge, so it sees the post-edge level.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      pending <= '0;
    end else if (!i_CommitMode) begin
      pending <= '0;
    end else if (slotWrap) begin
      pending <= levelNext;
    end else if (popReq) begin
      pending <= pending - LEVEL_W'(1);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_VoiceOpWriteEnable <= 1'b0;
      o_GlobalWriteEnable  <= 1'b0;
      o_VoiceOpParameter   <= '0;
      o_VoiceOpAddress     <= '0;
      o_GlobalAddress      <= '0;
      o_WriteValue         <= '0;
    end else begin
      o_VoiceOpWriteEnable <= popReq && (headEntry.kind == KIND_VOICE_OP);
      o_GlobalWriteEnable  <= popReq && (headEntry.kind == KIND_GLOBAL);
      if (popReq) begin
        o_WriteValue <= headEntry.value;
        if (headEntry.kind == KIND_VOICE_OP) begin
          o_VoiceOpParameter <= headEntry.addr[13:8];
          o_VoiceOpAddress   <= headEntry.addr[7:0];
        end else begin
          o_GlobalAddress <= headEntry.addr;
        end
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_DropCount <= '0;
    end else if (dropReq && (o_DropCount != 8'hFF)) begin
      o_DropCount <= o_DropCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_synth_control_sequencer.sv
// Bench for synth_control_sequencer: directed frame/commit/overflow/reject/reset steps and random
// host traffic, every cycle compared against a queue-based reference model of the write path.
module tb_synth_control_sequencer;

  localparam int NV    = 32;
  localparam int NO    = 8;
  localparam int DEPTH = 16;
  localparam int FRAME = NV * NO;

  logic        clk = 1'b0;
  logic        rstN;
  logic        we;
  logic [15:0] wnum;
  logic [15:0] wval;
  logic        mode;
  logic        ready;
  logic [7:0]  voiceOp;
  logic        frameStart;
  logic        voEn;
  logic [5:0]  voParam;
  logic [7:0]  voAddr;
  logic        glEn;
  logic [13:0] glAddr;
  logic [15:0] outVal;
  logic [4:0]  level;
  logic [7:0]  drops;

  logic        we2;
  logic [15:0] wnum2;
  logic [15:0] wval2;
  logic        ready2;
  logic [7:0]  voiceOp2;
  logic        fs2;
  logic        vo2En;
  logic [5:0]  vo2Param;
  logic [7:0]  vo2Addr;
  logic        gl2En;
  logic [13:0] gl2Addr;
  logic [15:0] val2;
  logic [4:0]  level2;
  logic [7:0]  drops2;

  always #5 clk = ~clk;

  synth_control_sequencer #(.NUM_VOICES(NV), .NUM_OPERATORS(NO), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock(clk), .i_Reset_n(rstN), .i_RegisterWriteEnable(we), .i_RegisterWriteNumber(wnum),
    .i_RegisterWriteValue(wval), .o_RegisterWriteReady(ready), .i_CommitMode(mode),
    .o_VoiceOperator(voiceOp), .o_FrameStart(frameStart), .o_VoiceOpWriteEnable(voEn),
    .o_VoiceOpParameter(voParam), .o_VoiceOpAddress(voAddr), .o_GlobalWriteEnable(glEn),
    .o_GlobalAddress(glAddr), .o_WriteValue(outVal), .o_FifoLevel(level), .o_DropCount(drops)
  );

  synth_control_sequencer #(.NUM_VOICES(12), .NUM_OPERATORS(8), .FIFO_DEPTH(16)) dut12 (
    .i_Clock(clk), .i_Reset_n(rstN), .i_RegisterWriteEnable(we2), .i_RegisterWriteNumber(wnum2),
    .i_RegisterWriteValue(wval2), .o_RegisterWriteReady(ready2), .i_CommitMode(mode),
    .o_VoiceOperator(voiceOp2), .o_FrameStart(fs2), .o_VoiceOpWriteEnable(vo2En),
    .o_VoiceOpParameter(vo2Param), .o_VoiceOpAddress(vo2Addr), .o_GlobalWriteEnable(gl2En),
    .o_GlobalAddress(gl2Addr), .o_WriteValue(val2), .o_FifoLevel(level2), .o_DropCount(drops2)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the host write queue as the spec describes it, plus the slot index.
  typedef struct {
    bit          isGlobal;
    logic [5:0]  param;
    logic [4:0]  voice;
    logic [2:0]  op;
    logic [13:0] gaddr;
    logic [15:0] val;
  } ent_t;

  ent_t        q[$];
  int          slot;
  int          pending;
  int          mDrops;
  bit          eVo;
  bit          eGl;
  bit          voSeen;
  bit          glSeen;
  logic [5:0]  eParam;
  logic [7:0]  eVoAddr;
  logic [13:0] eGlAddr;
  logic [15:0] eVal;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    bit   isVo;
    bit   isGl;
    bit   accept;
    bit   doPop;
    ent_t e;
    ent_t n;
    isVo   = (wnum[15:14] == 2'b11) && (int'(wnum[7:3]) < NV) && (int'(wnum[2:0]) < NO);
    isGl   = (wnum[15:14] == 2'b10);
    accept = we && (isVo || isGl) && (q.size() < DEPTH);
    if (we && !accept && mDrops < 255) mDrops++;
    doPop = (q.size() > 0) && (!mode || pending > 0);
    eVo = 0;
    eGl = 0;
    if (doPop) begin
      e    = q.pop_front();
      eVal = e.val;
      if (e.isGlobal) begin
        eGl = 1; glSeen = 1; eGlAddr = e.gaddr;
      end else begin
        eVo = 1; voSeen = 1; eParam = e.param; eVoAddr = {e.voice, e.op};
      end
    end
    if (accept) begin
      n.isGlobal = isGl;
      n.param    = wnum[13:8];
      n.voice    = wnum[7:3];
      n.op       = wnum[2:0];
      n.gaddr    = wnum[13:0];
      n.val      = wval;
      q.push_back(n);
    end
    if (!mode) pending = 0;
    else if (slot == FRAME - 1) pending = q.size();
    else if (doPop) pending--;
    slot = (slot + 1) % FRAME;
  endtask

  task automatic checkAll();
    check("slot", voiceOp, 32'((slot / NV) * 32 + (slot % NV)));
    check("frameStart", frameStart, slot == 0);
    check("voStrobe", voEn, eVo);
    check("glStrobe", glEn, eGl);
    check("level", level, q.size());
    check("ready", ready, q.size() < DEPTH);
    check("drops", drops, mDrops);
    if (voSeen) begin
      check("voParam", voParam, eParam);
      check("voAddr", voAddr, eVoAddr);
    end
    if (glSeen) check("glAddr", glAddr, eGlAddr);
    if (voSeen || glSeen) check("value", outVal, eVal);
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  // Asserts reset mid-cycle so the async path is observed before any clock edge.
  task automatic doReset(input int holdCycles);
    we  = 0;
    we2 = 0;
    #2 rstN = 0;
    #1;
    check("rstVoStrobe", voEn, 0);
    check("rstGlStrobe", glEn, 0);
    check("rstLevel", level, 0);
    check("rstSlot", voiceOp, 0);
    check("rstFrameStart", frameStart, 1);
    check("rstDrops", drops, 0);
    check("rstReady", ready, 1);
    check("rstSlot12", voiceOp2, 0);
    check("rstFrameStart12", fs2, 1);
    q.delete();
    pending = 0; slot = 0; mDrops = 0;
    eVo = 0; eGl = 0; voSeen = 0; glSeen = 0;
    repeat (holdCycles) @(posedge clk);
    @(negedge clk);
    rstN = 1;
    checkAll();
  endtask

  int fsPos[$];
  int stSlot[$];
  int stAddr[$];
  int cnt;
  int r;

  initial begin
    rstN = 0; we = 0; wnum = '0; wval = '0; mode = 0;
    we2 = 0; wnum2 = '0; wval2 = '0;
    @(negedge clk);
    doReset(2);

    // Two full frames of slot stepping
    if (frameStart) fsPos.push_back(0);
    for (int c = 1; c <= 2 * FRAME + 4; c++) begin
      tick();
      if (frameStart) fsPos.push_back(c);
    end
    check("fsCount", fsPos.size(), 3);
    if (fsPos.size() == 3) begin
      check("fsPos0", fsPos[0], 0);
      check("fsPos1", fsPos[1], 256);
      check("fsPos2", fsPos[2], 512);
    end

    // Immediate mode, single voice-op write
    mode = 0; we = 1; wnum = 16'hC00A; wval = 16'h1234;
    tick();
    we = 0;
    check("imm+1", voEn, 0);
    tick();
    check("imm+2", voEn, 1);
    check("immParam", voParam, 6'h00);
    check("immAddr", voAddr, 8'h0A);
    check("immVal", outVal, 16'h1234);
    tick();
    check("imm+3", voEn, 0);

    // Frame mode: three globals at slot 10 wait for the next frame
    mode = 1;
    for (int k = 0; k < FRAME && slot != 10; k++) tick();
    for (int k = 0; k < 3; k++) begin
      we = 1; wnum = 16'h8005 + 16'(k); wval = 16'h0A01 + 16'(k);
      tick();
    end
    we = 0;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if (glEn || voEn) begin
        stSlot.push_back(int'(voiceOp));
        stAddr.push_back(int'(glAddr));
      end
    end
    check("frameStrobes", stSlot.size(), 3);
    if (stSlot.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check("frameSlot", stSlot[k], k + 1);
        check("frameAddr", stAddr[k], 5 + k);
      end
    end

    // Overflow in frame mode
    for (int i = 0; i < 17; i++) begin
      we = 1; wnum = 16'hC000 | 16'(i << 3); wval = 16'h5500 + 16'(i);
      tick();
      if (i == 15) begin
        check("fullReady", ready, 0);
        check("fullLevel", level, 16);
      end
    end
    we = 0;
    check("ovfDrops", drops, 1);
    check("ovfLevel", level, 16);
    mode = 0;
    repeat (20) tick();
    check("drainLevel", level, 0);

    // Rejected addresses
    we = 1; wnum = 16'h4000; wval = 16'h0001;
    tick();
    we = 0;
    check("rejDrops", drops, 2);
    we2 = 1; wnum2 = 16'h4000; wval2 = 16'h0001;
    tick();
    wnum2 = 16'hC0A0;
    tick();
    we2 = 0;
    check("rej12Drops", drops2, 2);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rej12NoStrobe", vo2En | gl2En, 0);
    end
    check("rej12Level", level2, 0);
    we2 = 1; wnum2 = 16'hC05F; wval2 = 16'hBEEF;
    tick();
    wnum2 = 16'h8123; wval2 = 16'h0042;
    tick();
    we2 = 0;
    check("v11Strobe", vo2En, 1);
    check("v11Addr", vo2Addr, 8'h5F);
    check("v11Param", vo2Param, 6'h00);
    check("v11Val", val2, 16'hBEEF);
    tick();
    check("g12Strobe", gl2En, 1);
    check("g12Addr", gl2Addr, 14'h0123);
    check("g12Val", val2, 16'h0042);
    check("g12Ready", ready2, 1);
    for (int i = 0; i < 300; i++) begin
      we = 1; wnum = {1'b0, 15'($urandom)}; wval = 16'($urandom);
      tick();
    end
    we = 0;
    check("dropSat", drops, 255);

    // Random traffic against the model
    doReset(3);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) mode = ~mode;
      we = mode ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      r  = $urandom_range(0, 9);
      if (r < 6) wnum = {2'b11, 6'($urandom_range(0, 16)), 5'($urandom), 3'($urandom)};
      else if (r < 9) wnum = {2'b10, 14'($urandom)};
      else wnum = {1'b0, 15'($urandom)};
      wval = 16'($urandom);
      tick();
    end
    we = 0;

    // Reset with entries buffered mid-drain
    mode = 0;
    repeat (20) tick();
    mode = 1;
    for (int k = 0; k < FRAME && slot != FRAME - 12; k++) tick();
    for (int k = 0; k < 8; k++) begin
      we = 1; wnum = 16'h8100 + 16'(k); wval = 16'h7700 + 16'(k);
      tick();
    end
    we = 0;
    for (int k = 0; k < 40 && !glEn; k++) tick();
    check("midDrainFirst", glEn, 1);
    tick();
    tick();
    check("midDrainStrobe", glEn, 1);
    check("midDrainLevel", level, 5);
    doReset(2);
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (voEn || glEn) cnt++;
    end
    check("noStrobeAfterReset", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
